cu_seq_carry: RTL
=================

// Module: cu_seq_carry
// PURPOSE
//  Sequential carry unit feeding the sum-unit stage (su_2bits instances) of the CLA datapath.
//  - Accepts WIDTH-bit operands a, b and carry-in cin.
//  - Produces the propagate vector p and the per-bit carry-in vector c, so downstream s = c ^ p.
//  - Resolves carries one 2-bit group per clock through a 2-bit lookahead cell.
//  - Valid/ready handshakes on both sides.
// PARAMETERS
//  WIDTH  8  operand width; even, >= 2; number of groups NGRP = WIDTH/2
// PORTS
//  clk        in   1      single clock, all state on rising edge
//  rst        in   1      reset, asynchronous, active-high
//  in_valid   in   1      operand valid
//  in_ready   out  1      block can accept operands
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry into bit 0
//  out_valid  out  1      c/p/cout valid for the sum unit
//  out_ready  in   1      sum unit consumes result
//  p          out  WIDTH  propagate, a ^ b
//  c          out  WIDTH  c[i] = carry into bit i; c[0] = cin
//  cout       out  1      carry out of bit WIDTH-1
//  ovf        out  1      signed overflow; present only with CU_OVF_FLAG_EN
// BEHAVIOUR
//  Reset values: in_ready=1, out_valid=0, p=0, c=0, cout=0, ovf=0; state=IDLE, grp_idx=0.
//  FSM states:
//   - IDLE: in_ready=1. On in_valid: latch p=a^b, g=a&b, carry_reg=cin, grp_idx=0; go to RUN.
//   - RUN: in_ready=0. Each cycle, group k=grp_idx computes
//       c[2k]   = carry_reg
//       c[2k+1] = g[2k] | p[2k]&carry_reg
//       carry_reg <= g[2k+1] | p[2k+1]&c[2k+1]
//     grp_idx increments. On k = NGRP-1: cout <= group carry-out; go to DONE.
//   - DONE: out_valid=1, in_ready=0. p/c/cout/ovf held stable until out_ready.
//     On out_valid & out_ready: go to IDLE, clear out_valid.
//  Latency: out_valid rises exactly NGRP cycles after the accepting edge.
//  Throughput: one result per NGRP+2 cycles.
//  Handshake rules:
//   - Accept occurs only on an edge where in_ready & in_valid.
//   - in_valid in RUN or DONE is ignored; the operand is not captured.
//   - No same-cycle bypass: the cycle after a DONE->IDLE handoff always shows in_ready=1.
//  Registered outputs: c/p update only in RUN (c) or at accept (p); no combinational path in->out.
//  Unprocessed bits of c read 0 during RUN; downstream must qualify with out_valid.
//  Widths:
//   - grp_idx is clog2(NGRP) bits, minimum 1; it does not wrap.
//   - The FSM leaves RUN when grp_idx = NGRP-1.
//  Reset asserted mid-RUN or mid-DONE: immediate abort, all outputs to reset values; the
//  latched operand is discarded.
// CONFIGURATION
//  CU_OVF_FLAG_EN defined: ovf port exists; ovf <= cout ^ c[WIDTH-1], set at RUN->DONE,
//   held through DONE, cleared at accept.
//  CU_OVF_FLAG_EN undefined: no ovf port, no ovf logic; all other timing identical.
// STRUCTURE
//  Package cu_pkg:
//   - state enum {IDLE, RUN, DONE}
//   - GRP_BITS = 2
//   - function clog2 for grp_idx width
//  Sub-module cla_2bit_cell (combinational):
//   - inputs g[1:0], p[1:0], ci
//   - outputs c[1:0], co
//   - one instance, indexed by grp_idx
// TESTING (WIDTH=8)
//  1. a=0x00 b=0x00 cin=0 -> out_valid 4 cycles after accept; p=0x00 c=0x00 cout=0.
//  2. a=0xFF b=0x01 cin=0 -> p=0xFE c=0xFE cout=1 (c^p = 0x00).
//  3. a=0x55 b=0xAA cin=1 -> p=0xFF c=0xFF cout=1; back-to-back ops show in_ready low until handoff.
//  4. out_ready=0 for 5 cycles in DONE, in_valid=1 with a new operand -> out_valid and c/p/cout
//     stable; new operand not captured.
//  5. rst pulse after 2 RUN cycles -> same cycle out_valid=0 c=0 p=0; in_ready=1 after release.
//  6. CU_OVF_FLAG_EN: a=0x7F b=0x01 cin=0 -> c=0xFE cout=0 ovf=1;
//     a=0xFF b=0x01 -> ovf=0.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and helpers for the sequential carry unit.
package cu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int unsigned GRP_BITS = 2;

   // Ceiling log2; clog2(1) = 0.
   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int unsigned v = n - 1; v > 0; v = v >> 1) r++;
      return r;
   endfunction

endpackage

// File: rtl/cla_2bit_cell.sv
// Combinational 2-bit carry-lookahead cell: carries into both bits plus group carry-out.
module cla_2bit_cell (
   input  logic [1:0] g,
   input  logic [1:0] p,
   input  logic       ci,
   output logic [1:0] c,
   output logic       co
);

   assign c[0] = ci;
   assign c[1] = g[0] | (p[0] & ci);
   assign co   = g[1] | (p[1] & c[1]);

endmodule

// File: rtl/cu_seq_carry.sv
// Sequential carry unit: resolves one 2-bit group per clock and hands p/c/cout to the sum unit.
// Optional signed-overflow flag on port ovf when CU_OVF_FLAG_EN is defined.
module cu_seq_carry
   import cu_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] p,
   output logic [WIDTH-1:0] c,
   output logic             cout
`ifdef CU_OVF_FLAG_EN
   ,
   output logic             ovf
`endif
);

   localparam int unsigned NGRP   = WIDTH / GRP_BITS;
   localparam int unsigned GIDX_W = (clog2(NGRP) < 1) ? 1 : clog2(NGRP);
   localparam logic [GIDX_W-1:0] LAST_GRP = GIDX_W'(NGRP - 1);

   state_t              state;
   logic [WIDTH-1:0]    g;
   logic                carry_reg;
   logic [GIDX_W-1:0]   grp_idx;
   logic [GIDX_W:0]     bit_lo;
   logic [1:0]          cell_c;
   logic                cell_co;

   assign bit_lo = {grp_idx, 1'b0};

   cla_2bit_cell u_cell (
      .g  (g[bit_lo +: 2]),
      .p  (p[bit_lo +: 2]),
      .ci (carry_reg),
      .c  (cell_c),
      .co (cell_co)
   );

   // Control FSM with registered handshake and datapath outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         p         <= '0;
         g         <= '0;
         c         <= '0;
         cout      <= 1'b0;
         carry_reg <= 1'b0;
         grp_idx   <= '0;
`ifdef CU_OVF_FLAG_EN
         ovf       <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  p         <= a ^ b;
                  g         <= a & b;
                  c         <= '0;
                  cout      <= 1'b0;
                  carry_reg <= cin;
                  grp_idx   <= '0;
                  in_ready  <= 1'b0;
                  state     <= RUN;
`ifdef CU_OVF_FLAG_EN
                  ovf       <= 1'b0;
`endif
               end
            end
            RUN: begin
               c[bit_lo +: 2] <= cell_c;
               carry_reg      <= cell_co;
               if (grp_idx == LAST_GRP) begin
                  cout      <= cell_co;
                  out_valid <= 1'b1;
                  state     <= DONE;
`ifdef CU_OVF_FLAG_EN
                  // Last group's upper carry is the carry into the sign bit.
                  ovf       <= cell_co ^ cell_c[1];
`endif
               end else begin
                  grp_idx <= grp_idx + GIDX_W'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
